axi_full_ram_slave: RTL and testbench

//  Parametrised AXI4-full slave RAM. Replaces the fixed virtual memory used by the video-stitching benches.

---
 rtl/axi_full_ram_slave_if.sv | 81 ++++++++
 rtl/axi_full_ram_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_full_ram_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_full_ram_slave_if.sv
// AXI4-full bundle between a burst master and the RAM slave.
interface axi_full_ram_slave_if #(
    parameter int ID_W   = 1,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wuser;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                buser;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                aruser;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                ruser;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache,
        input  awprot, awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache,
        input  arprot, arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache,
        output awprot, awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache,
        output arprot, arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_full_ram_slave.sv
// AXI4-full slave RAM: FIXED/INCR/WRAP bursts, byte strobes, range
// checking, programmable read latency and periodic back-pressure.
module axi_full_ram_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int MEM_DEPTH    = 4096,
    parameter int RD_LATENCY   = 2,
    parameter int STALL_PERIOD = 0
) (
    input logic S_AXI_ACLK,
    input logic S_AXI_ARESETN,
    axi_full_ram_slave_if.slave s_axi
);
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int IW  = C_S_AXI_ID_WIDTH;
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int NB  = DW / 8;
    localparam int OFF = $clog2(NB);
    localparam int IXW = $clog2(MEM_DEPTH);
    localparam int SCW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [AW-1:0]  ONE       = AW'(1);
    localparam logic [AW-1:0]  MEM_BYTES = AW'(MEM_DEPTH * NB);
    localparam logic [SCW-1:0] SC_TOP    = SCW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
    localparam logic [3:0]     LAT_TOP   = 4'(RD_LATENCY - 1);
    localparam logic [1:0] FIXED = 2'b00, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
    endfunction

    function automatic logic [IXW-1:0] word_idx(input logic [AW-1:0] a);
        return IXW'((a - BASE_ADDR) >> OFF);
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                input logic [2:0] size,
                                                input logic [1:0] burst,
                                                input logic [7:0] len);
        logic [2:0] s;
        logic [AW-1:0] b, span;
        s = (size > 3'(OFF)) ? 3'(OFF) : size;
        b = ONE << s;
        span = b * (AW'(len) + ONE);
        if (burst == FIXED)
            return a;
        // wrap keeps the upper bits and rolls the offset within the span
        if (burst == WRAP && wrap_ok(len))
            return (a & ~(span - ONE)) | ((a + b) & (span - ONE));
        return a + b;
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];
    logic run;

    w_state_t w_state, w_next;
    logic [IW-1:0] w_id;
    logic [AW-1:0] w_addr;
    logic [7:0] w_len, w_beat;
    logic [2:0] w_size;
    logic [1:0] w_burst;
    logic w_err, w_stall, aw_hs, w_hs, w_last, w_ok;
    logic [SCW-1:0] w_scnt;

    r_state_t r_state, r_next;
    logic [IW-1:0] r_id;
    logic [AW-1:0] r_addr, r_nxt, f_addr;
    logic [7:0] r_len, r_beat;
    logic [2:0] r_size;
    logic [1:0] r_burst, rresp_q;
    logic [3:0] r_wait;
    logic r_stall, ar_hs, r_hs, r_last, r_fetch, r_ok;
    logic [SCW-1:0] r_scnt;
    logic [DW-1:0] rdata_q;

    assign aw_hs  = s_axi.awvalid && run && w_state == W_IDLE;
    assign w_hs   = s_axi.wvalid && !w_stall && w_state == W_DATA;
    assign w_last = w_beat == w_len;
    assign w_ok   = in_range(w_addr) && (w_burst != WRAP || wrap_ok(w_len));

    assign ar_hs   = s_axi.arvalid && run && r_state == R_IDLE;
    assign r_hs    = s_axi.rready && !r_stall && r_state == R_DATA;
    assign r_last  = r_beat == r_len;
    assign r_nxt   = next_addr(r_addr, r_size, r_burst, r_len);
    assign f_addr  = (r_state == R_WAIT) ? r_addr : r_nxt;
    assign r_ok    = in_range(f_addr) && (r_burst != WRAP || wrap_ok(r_len));
    assign r_fetch = (r_state == R_WAIT && r_wait == LAT_TOP) || (r_hs && !r_last);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            run     <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            run     <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi.awready = run;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = !w_stall;
                if (w_hs && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi.arready = run;
                if (ar_hs) r_next = R_WAIT;
            end
            R_WAIT: if (r_wait == LAT_TOP) r_next = R_DATA;
            R_DATA: begin
                s_axi.rvalid = !r_stall;
                if (r_hs && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0;
            w_burst <= '0; w_beat <= '0; w_err <= 1'b0;
            w_scnt <= '0; w_stall <= 1'b0;
        end else if (aw_hs) begin
            w_id <= s_axi.awid; w_addr <= s_axi.awaddr; w_len <= s_axi.awlen;
            w_size <= s_axi.awsize; w_burst <= s_axi.awburst; w_beat <= '0;
            w_err <= 1'b0; w_scnt <= '0; w_stall <= 1'b0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
            w_beat <= w_beat + 8'd1;
            if (!w_ok || (s_axi.wlast != w_last)) w_err <= 1'b1;
            if (STALL_PERIOD > 0) begin
                w_scnt  <= (w_scnt == SC_TOP) ? '0 : w_scnt + 1'b1;
                w_stall <= w_scnt == SC_TOP;
            end
        end else begin
            w_stall <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0;
            r_burst <= '0; r_beat <= '0; r_wait <= '0;
            r_scnt <= '0; r_stall <= 1'b0; rresp_q <= OKAY;
        end else begin
            if (ar_hs) begin
                r_id <= s_axi.arid; r_addr <= s_axi.araddr; r_len <= s_axi.arlen;
                r_size <= s_axi.arsize; r_burst <= s_axi.arburst; r_beat <= '0;
                r_wait <= '0; r_scnt <= '0; r_stall <= 1'b0;
            end else if (r_hs) begin
                r_addr <= r_nxt;
                r_beat <= r_beat + 8'd1;
                if (STALL_PERIOD > 0) begin
                    r_scnt  <= (r_scnt == SC_TOP) ? '0 : r_scnt + 1'b1;
                    r_stall <= r_scnt == SC_TOP;
                end
            end else begin
                r_stall <= 1'b0;
                if (r_state == R_WAIT) r_wait <= r_wait + 4'd1;
            end
            if (r_fetch) rresp_q <= r_ok ? OKAY : SLVERR;
        end
    end

    // one process owns the array; the nonblocking read sees pre-write data
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs && w_ok)
            for (int i = 0; i < NB; i++)
                if (s_axi.wstrb[i])
                    mem[word_idx(w_addr)][8*i +: 8] <= s_axi.wdata[8*i +: 8];
        if (r_fetch)
            rdata_q <= r_ok ? mem[word_idx(f_addr)] : '0;
    end

    assign s_axi.bid   = w_id;
    assign s_axi.bresp = w_err ? SLVERR : OKAY;
    assign s_axi.buser = 1'b0;
    assign s_axi.rid   = r_id;
    assign s_axi.rdata = rdata_q;
    assign s_axi.rresp = rresp_q;
    assign s_axi.rlast = r_last && r_state == R_DATA;
    assign s_axi.ruser = 1'b0;

    logic unused_sideband;
    assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                               s_axi.awqos, s_axi.awregion, s_axi.awuser,
                               s_axi.wuser, s_axi.arlock, s_axi.arcache,
                               s_axi.arprot, s_axi.arqos, s_axi.arregion,
                               s_axi.aruser};
endmodule

// File: tb/tb_axi_full_ram_slave.sv
// Directed bench for axi_full_ram_slave with read latency 5 and
// back-pressure every 4 beats on both channels.
module tb_axi_full_ram_slave;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_full_ram_slave_if #(.ID_W(1), .DATA_W(128), .ADDR_W(32)) ax ();

    axi_full_ram_slave #(
        .RD_LATENCY(5),
        .STALL_PERIOD(4)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(ax)
    );

    int total = 0;
    int bad = 0;
    int tmo = 0;

    logic [1:0]   b_resp;
    logic         b_id;
    logic         b_seen;
    logic [127:0] exp_d [16];
    logic [127:0] r_data [16];
    logic [15:0]  r_lastv;
    logic [15:0]  r_gapv;
    logic [31:0]  r_respv;
    int           r_gapn, r_derr, r_lat;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] bt, input logic [127:0] d0,
                      input logic [127:0] step, input logic [15:0] strb,
                      input int abort_at);
        int n;
        b_seen = 1'b0;
        ax.awaddr = a; ax.awlen = len; ax.awsize = 3'd4;
        ax.awburst = bt; ax.awid = 1'b1; ax.awvalid = 1'b1;
        n = 0;
        while (!ax.awready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) tmo++;
        @(posedge clk); #1;
        ax.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ax.wdata = d0 + step * i; ax.wstrb = strb;
            ax.wlast = (i == int'(len)); ax.wvalid = 1'b1;
            if (i == abort_at) begin
                rst_n = 1'b0;
                ax.wvalid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                rst_n = 1'b1;
                return;
            end
            n = 0;
            while (!ax.wready && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) tmo++;
            @(posedge clk); #1;
        end
        ax.wvalid = 1'b0; ax.wlast = 1'b0;
        n = 0;
        while (!ax.bvalid && n < 50) begin @(posedge clk); #1; n++; end
        b_seen = ax.bvalid; b_resp = ax.bresp; b_id = ax.bid;
        ax.bready = 1'b1;
        @(posedge clk); #1;
        ax.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] bt, input logic tog);
        int n, beat, cyc;
        for (int i = 0; i < 16; i++) r_data[i] = '0;
        r_lastv = '0; r_respv = '0; r_gapv = '0; r_gapn = 0; r_derr = 0;
        ax.araddr = a; ax.arlen = len; ax.arsize = 3'd4;
        ax.arburst = bt; ax.arid = 1'b1; ax.arvalid = 1'b1;
        n = 0;
        while (!ax.arready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) tmo++;
        @(posedge clk); #1;
        ax.arvalid = 1'b0;
        r_lat = 0;
        while (!ax.rvalid && r_lat < 50) begin @(posedge clk); #1; r_lat++; end
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 400) begin
            ax.rready = tog ? cyc[0] : 1'b1;
            if (ax.rvalid) begin
                if (ax.rdata !== exp_d[beat]) r_derr++;
                if (ax.rready) begin
                    r_data[beat] = ax.rdata;
                    r_lastv[beat] = ax.rlast;
                    r_respv[2*beat +: 2] = ax.rresp;
                    beat++;
                end
            end else if (beat > 0) begin
                r_gapv[beat-1] = 1'b1;
                r_gapn++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) tmo++;
        ax.rready = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [127:0] dtop;
        {ax.awid, ax.awaddr, ax.awlen, ax.awsize, ax.awburst} = '0;
        {ax.awlock, ax.awcache, ax.awprot, ax.awqos, ax.awregion} = '0;
        {ax.awuser, ax.awvalid, ax.wdata, ax.wstrb, ax.wlast} = '0;
        {ax.wuser, ax.wvalid, ax.bready} = '0;
        {ax.arid, ax.araddr, ax.arlen, ax.arsize, ax.arburst} = '0;
        {ax.arlock, ax.arcache, ax.arprot, ax.arqos, ax.arregion} = '0;
        {ax.aruser, ax.arvalid, ax.rready} = '0;

        repeat (3) begin @(posedge clk); #1; end
        chk("rst_vr", {ax.awready, ax.arready, ax.wready, ax.bvalid, ax.rvalid}, 0);
        chk("rst_resp", {ax.bresp, ax.rresp}, 0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_rdy", {ax.awready, ax.arready}, 2'b11);

        wr(32'h1000_0000, 8'd15, INCR, 128'd0, 128'd1, 16'hFFFF, -1);
        chk("t1_b", b_seen, 1'b1);
        chk("t1_bresp", b_resp, 2'b00);
        chk("t1_bid", b_id, 1'b1);
        for (int i = 0; i < 16; i++) exp_d[i] = 128'(i);
        rd(32'h1000_0000, 8'd15, INCR, 1'b0);
        chk("t1_data", r_derr, 0);
        chk("t1_last", r_lastv, 16'h8000);
        chk("t1_rresp", r_respv, 0);
        chk("t1_lat", r_lat, 5);
        chk("t1_gap", r_gapv, 16'h0888);

        wr(32'h1000_0100, 8'd0, INCR, '1, 128'd0, 16'hFFFF, -1);
        wr(32'h1000_0100, 8'd0, INCR, 128'd0, 128'd0, 16'h00FF, -1);
        chk("t2_bresp", b_resp, 2'b00);
        exp_d[0] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        rd(32'h1000_0100, 8'd0, INCR, 1'b0);
        chk("t2_data", r_data[0], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        exp_d[0] = 128'd3; exp_d[1] = 128'd0;
        exp_d[2] = 128'd1; exp_d[3] = 128'd2;
        rd(32'h1000_0030, 8'd3, WRAP, 1'b0);
        chk("t3_wrap_data", r_derr, 0);
        chk("t3_wrap_last", r_lastv, 16'h0008);
        chk("t3_wrap_resp", r_respv, 0);
        rd(32'h1000_0000, 8'd2, WRAP, 1'b0);
        chk("t3_badwrap_resp", r_respv, 32'h2A);
        chk("t3_badwrap_last", r_lastv, 16'h0004);

        for (int i = 0; i < 16; i++) exp_d[i] = 128'(i);
        rd(32'h1000_0000, 8'd15, INCR, 1'b1);
        chk("t4_lat", r_lat, 5);
        chk("t4_hold", r_derr, 0);
        chk("t4_gap", r_gapv, 16'h0888);
        chk("t4_gapn", r_gapn, 3);
        chk("t4_last", r_lastv, 16'h8000);

        dtop = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        wr(32'h1000_FFF0, 8'd0, INCR, dtop, 128'd0, 16'hFFFF, -1);
        chk("t5_top_bresp", b_resp, 2'b00);
        wr(32'h0FFF_FFF0, 8'd0, INCR, {4{32'h5555_AAAA}}, 128'd0, 16'hFFFF, -1);
        chk("t5_oor_bresp", b_resp, 2'b10);
        exp_d[0] = dtop; exp_d[1] = 128'd0;
        rd(32'h1000_FFF0, 8'd1, INCR, 1'b0);
        chk("t5_rdata", r_derr, 0);
        chk("t5_rresp", r_respv, 32'h8);

        wr(32'h1000_0200, 8'd15, INCR, 128'd100, 128'd1, 16'hFFFF, 7);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (ax.bvalid) cnt++;
            @(posedge clk); #1;
        end
        chk("t6_no_b", cnt, 0);
        chk("t6_awready", ax.awready, 1'b1);
        for (int i = 0; i < 7; i++) exp_d[i] = 128'(100 + i);
        rd(32'h1000_0200, 8'd6, INCR, 1'b0);
        chk("t6_kept", r_derr, 0);
        chk("t6_rresp", r_respv, 0);

        wr(32'h1000_0300, 8'd3, FIXED, 128'd40, 128'd1, 16'hFFFF, -1);
        exp_d[0] = 128'd43;
        rd(32'h1000_0300, 8'd0, INCR, 1'b0);
        chk("fixed_data", r_data[0], 128'd43);

        chk("timeout", tmo, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
